// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART TX line arbiter.
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPfxId,
        StPfxSep,
        StStream
    } arb_state_e;

    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    // Requester id width; a single requester still needs one bit.
    function automatic int unsigned id_width(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_rr_pick.sv
// Combinational round-robin picker: first valid index at or after rr_ptr_i, wrapping.
module uart_tx_rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]               valid_i,
    input  logic [id_width(NUM_REQ)-1:0]     rr_ptr_i,
    output logic [id_width(NUM_REQ)-1:0]     idx_o,
    output logic                             any_o
);

    localparam int unsigned IdW = id_width(NUM_REQ);

    logic [NUM_REQ-1:0] rot;
    int unsigned        sum;

    always_comb begin
        // rot[k] is the valid bit of requester (rr_ptr + k) mod NUM_REQ.
        rot   = NUM_REQ'({valid_i, valid_i} >> rr_ptr_i);
        sum   = 0;
        idx_o = '0;
        any_o = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!any_o && rot[k]) begin
                any_o = 1'b1;
                sum   = 32'(rr_ptr_i) + k;
                idx_o = IdW'((sum >= NUM_REQ) ? (sum - NUM_REQ) : sum);
            end
        end
    end

endmodule

// File: rtl/uart_tx_line_arbiter.sv
// Line-atomic arbiter sharing one UART TX FIFO write port among several byte streams,
// optionally tagging each granted line with an "<id>:" prefix.
module uart_tx_line_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 2,
    parameter bit          PREFIX_EN    = 1'b1,
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic                          sysclk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*8-1:0]          req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          fifo_full_i,
    output logic                          fifo_wr_o,
    output logic [7:0]                    fifo_wdata_o,
    output logic                          busy_o,
    output logic [id_width(NUM_REQ)-1:0]  owner_o,
    output logic                          timeout_o
);

    localparam int unsigned IdW       = id_width(NUM_REQ);
    localparam bit          TimeoutEn = (LOCK_TIMEOUT != 0);
    localparam int unsigned CntW      = TimeoutEn ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntLast = TimeoutEn ? CntW'(LOCK_TIMEOUT - 1) : '0;
    localparam logic [IdW-1:0]  LastId  = IdW'(NUM_REQ - 1);

    arb_state_e      state_q;
    logic [IdW-1:0]  owner_q;
    logic [IdW-1:0]  rr_ptr_q;
    logic [CntW-1:0] idle_cnt_q;
    logic            timeout_q;

    logic [IdW-1:0]  rr_next;
    logic [IdW-1:0]  pick_idx;
    logic            pick_any;
    logic            owner_valid;
    logic [7:0]      owner_byte;
    logic            accept;
    logic            lf_accept;
    logic            idle_tick;
    logic            timeout_hit;
    logic [7:0]      req_byte [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_byte[g] = req_data_i[8*g +: 8];
    end

    uart_tx_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .valid_i  (req_valid_i),
        .rr_ptr_i (rr_ptr_q),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    always_comb begin
        owner_valid = req_valid_i[owner_q];
        owner_byte  = req_byte[owner_q];
        accept      = (state_q == StStream) && owner_valid && !fifo_full_i;
        lf_accept   = accept && (owner_byte == ASCII_LF);
        // A full FIFO stalls the idle counter, so back-pressure never forces a release.
        idle_tick   = (state_q == StStream) && !owner_valid && !fifo_full_i;
        timeout_hit = TimeoutEn && idle_tick && (idle_cnt_q == CntLast);
        rr_next     = (owner_q == LastId) ? '0 : owner_q + IdW'(1);
    end

    always_comb begin
        req_ready_o  = '0;
        fifo_wr_o    = 1'b0;
        fifo_wdata_o = 8'h00;
        unique case (state_q)
            StPfxId: begin
                if (!fifo_full_i) begin
                    fifo_wr_o    = 1'b1;
                    fifo_wdata_o = ASCII_ZERO + 8'(owner_q);
                end
            end
            StPfxSep: begin
                if (!fifo_full_i) begin
                    fifo_wr_o    = 1'b1;
                    fifo_wdata_o = ASCII_COLON;
                end
            end
            StStream: begin
                req_ready_o[owner_q] = !fifo_full_i;
                if (accept) begin
                    fifo_wr_o    = 1'b1;
                    fifo_wdata_o = owner_byte;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pick_any) begin
                        owner_q    <= pick_idx;
                        idle_cnt_q <= '0;
                        state_q    <= PREFIX_EN ? StPfxId : StStream;
                    end
                end
                StPfxId: begin
                    if (!fifo_full_i) begin
                        state_q <= StPfxSep;
                    end
                end
                StPfxSep: begin
                    if (!fifo_full_i) begin
                        idle_cnt_q <= '0;
                        state_q    <= StStream;
                    end
                end
                StStream: begin
                    if (accept) begin
                        idle_cnt_q <= '0;
                        if (lf_accept) begin
                            rr_ptr_q <= rr_next;
                            state_q  <= StIdle;
                        end
                    end else if (timeout_hit) begin
                        idle_cnt_q <= '0;
                        rr_ptr_q   <= rr_next;
                        timeout_q  <= 1'b1;
                        state_q    <= StIdle;
                    end else if (TimeoutEn && idle_tick && (idle_cnt_q != {CntW{1'b1}})) begin
                        idle_cnt_q <= idle_cnt_q + CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o    = (state_q != StIdle);
    assign owner_o   = owner_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_uart_tx_line_arbiter.sv
// Scoreboard bench: instance A (prefix on, timeout 8), instance B (no prefix, no timeout).
module tb_uart_tx_line_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  a_valid, b_valid, a_ready, b_ready;
    logic [15:0] a_data, b_data;
    logic        a_full, b_full, a_wr, b_wr, a_busy, b_busy, a_tmo, b_tmo;
    logic [7:0]  a_wdata, b_wdata;
    logic [0:0]  a_owner, b_owner;

    logic [7:0]  exp_a[$];
    logic [7:0]  exp_b[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [1:0]  a_acc, b_acc, a_ready_s, b_ready_s;
    logic        a_wr_s, a_busy_s, a_tmo_s, b_busy_s, b_tmo_s;
    logic        tmo_seen_a, tmo_seen_b;

    always #5 clk = ~clk;

    uart_tx_line_arbiter #(
        .NUM_REQ      (2),
        .PREFIX_EN    (1'b1),
        .LOCK_TIMEOUT (8)
    ) u_dut_a (
        .sysclk_i     (clk),
        .rst_i        (rst),
        .req_valid_i  (a_valid),
        .req_data_i   (a_data),
        .req_ready_o  (a_ready),
        .fifo_full_i  (a_full),
        .fifo_wr_o    (a_wr),
        .fifo_wdata_o (a_wdata),
        .busy_o       (a_busy),
        .owner_o      (a_owner),
        .timeout_o    (a_tmo)
    );

    uart_tx_line_arbiter #(
        .NUM_REQ      (2),
        .PREFIX_EN    (1'b0),
        .LOCK_TIMEOUT (0)
    ) u_dut_b (
        .sysclk_i     (clk),
        .rst_i        (rst),
        .req_valid_i  (b_valid),
        .req_data_i   (b_data),
        .req_ready_o  (b_ready),
        .fifo_full_i  (b_full),
        .fifo_wr_o    (b_wr),
        .fifo_wdata_o (b_wdata),
        .busy_o       (b_busy),
        .owner_o      (b_owner),
        .timeout_o    (b_tmo)
    );

    task automatic push_a(input string s);
        for (int i = 0; i < s.len(); i++) exp_a.push_back(s[i]);
    endtask

    task automatic push_b(input string s);
        for (int i = 0; i < s.len(); i++) exp_b.push_back(s[i]);
    endtask

    // One clock: sample at the falling edge, score FIFO writes, return 1 ns after the rise.
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        a_acc = a_valid & a_ready;
        b_acc = b_valid & b_ready;
        a_ready_s = a_ready;
        b_ready_s = b_ready;
        a_wr_s = a_wr;
        a_busy_s = a_busy;
        a_tmo_s = a_tmo;
        b_busy_s = b_busy;
        b_tmo_s = b_tmo;
        if (a_tmo) tmo_seen_a = 1'b1;
        if (b_tmo) tmo_seen_b = 1'b1;
        if (a_wr) begin
            n_checks++;
            if (a_full !== 1'b0) begin
                n_fail++;
                $display("FAIL a_wr_while_full: full=%0b during write, required 0", a_full);
            end
            n_checks++;
            if (exp_a.size() == 0) begin
                n_fail++;
                $display("FAIL a_unexpected_write: got %02h, required no write", a_wdata);
            end else begin
                e = exp_a.pop_front();
                if (a_wdata !== e) begin
                    n_fail++;
                    $display("FAIL a_wdata: got %02h, required %02h", a_wdata, e);
                end
            end
        end else begin
            n_checks++;
            if (a_wdata !== 8'h00) begin
                n_fail++;
                $display("FAIL a_wdata_idle: got %02h, required 00", a_wdata);
            end
        end
        if (b_wr) begin
            n_checks++;
            if (b_full !== 1'b0) begin
                n_fail++;
                $display("FAIL b_wr_while_full: full=%0b during write, required 0", b_full);
            end
            n_checks++;
            if (exp_b.size() == 0) begin
                n_fail++;
                $display("FAIL b_unexpected_write: got %02h, required no write", b_wdata);
            end else begin
                e = exp_b.pop_front();
                if (b_wdata !== e) begin
                    n_fail++;
                    $display("FAIL b_wdata: got %02h, required %02h", b_wdata, e);
                end
            end
        end else begin
            n_checks++;
            if (b_wdata !== 8'h00) begin
                n_fail++;
                $display("FAIL b_wdata_idle: got %02h, required 00", b_wdata);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Requester model: offers s0 on req0 and s1 on req1, advancing on each accept.
    task automatic drive(input int inst, input string s0, input string s1, input int budget,
                         output bit done, output int overlap);
        int i0, i1;
        logic [1:0]  v, acc, rdy;
        logic [15:0] d;
        i0 = 0;
        i1 = 0;
        done = 1'b0;
        overlap = 0;
        for (int n = 0; n < budget; n++) begin
            v[0] = (i0 < s0.len());
            v[1] = (i1 < s1.len());
            d[7:0]  = v[0] ? s0[i0] : 8'h00;
            d[15:8] = v[1] ? s1[i1] : 8'h00;
            if (inst == 0) begin
                a_valid = v;
                a_data  = d;
            end else begin
                b_valid = v;
                b_data  = d;
            end
            tick();
            acc = (inst == 0) ? a_acc : b_acc;
            rdy = (inst == 0) ? a_ready_s : b_ready_s;
            if (rdy[1] && (i0 < s0.len())) overlap++;
            if (acc[0]) i0++;
            if (acc[1]) i1++;
            if ((i0 == s0.len()) && (i1 == s1.len())) begin
                done = 1'b1;
                break;
            end
        end
        if (inst == 0) a_valid = 2'b00;
        else b_valid = 2'b00;
    endtask

    task automatic test_reset();
        a_valid = 2'b11;
        b_valid = 2'b11;
        a_data = 16'h4241;
        b_data = 16'h4241;
        a_full = 1'b0;
        b_full = 1'b0;
        rst = 1'b1;
        #12;
        n_checks++; if (a_ready !== 2'b00) begin n_fail++; $display("FAIL rst_a_ready: got %b, required 00", a_ready); end
        n_checks++; if (a_wr !== 1'b0) begin n_fail++; $display("FAIL rst_a_wr: got %b, required 0", a_wr); end
        n_checks++; if (a_wdata !== 8'h00) begin n_fail++; $display("FAIL rst_a_wdata: got %02h, required 00", a_wdata); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rst_a_busy: got %b, required 0", a_busy); end
        n_checks++; if (a_owner !== 1'b0) begin n_fail++; $display("FAIL rst_a_owner: got %0d, required 0", a_owner); end
        n_checks++; if (a_tmo !== 1'b0) begin n_fail++; $display("FAIL rst_a_timeout: got %b, required 0", a_tmo); end
        n_checks++; if (b_ready !== 2'b00) begin n_fail++; $display("FAIL rst_b_ready: got %b, required 00", b_ready); end
        n_checks++; if (b_wr !== 1'b0) begin n_fail++; $display("FAIL rst_b_wr: got %b, required 0", b_wr); end
        a_valid = 2'b00;
        b_valid = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL idle_a_busy: got %b, required 0", a_busy); end
    endtask

    task automatic test_contention();
        bit done;
        int ov;
        push_a("0:X\n1:Y\n");
        drive(0, "X\n", "Y\n", 40, done, ov);
        n_checks++; if (!done) begin n_fail++; $display("FAIL contention_done: got 0, required 1"); end
        n_checks++; if (ov != 0) begin n_fail++; $display("FAIL contention_ready1_early: got %0d cycles, required 0", ov); end
        n_checks++; if (exp_a.size() != 0) begin n_fail++; $display("FAIL contention_leftover: got %0d bytes, required 0", exp_a.size()); end
    endtask

    task automatic test_single_line();
        bit done;
        int ov;
        push_a("0:AB\n");
        drive(0, "AB\n", "", 40, done, ov);
        n_checks++; if (!done) begin n_fail++; $display("FAIL single_done: got 0, required 1"); end
        n_checks++; if (a_busy_s !== 1'b1) begin n_fail++; $display("FAIL single_busy_at_lf: got %b, required 1", a_busy_s); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after_lf: got %b, required 0", a_busy); end
        n_checks++; if (exp_a.size() != 0) begin n_fail++; $display("FAIL single_leftover: got %0d bytes, required 0", exp_a.size()); end
    endtask

    task automatic test_full_stall();
        bit done;
        int ov;
        tmo_seen_a = 1'b0;
        push_a("0:Z\n");
        a_valid = 2'b01;
        a_data = {8'h00, 8'h5A};
        tick();
        tick();
        a_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (a_wr_s !== 1'b0) begin n_fail++; $display("FAIL stall_wr: got %b, required 0", a_wr_s); end
        end
        a_full = 1'b0;
        drive(0, "Z\n", "", 40, done, ov);
        n_checks++; if (!done) begin n_fail++; $display("FAIL stall_done: got 0, required 1"); end
        n_checks++; if (exp_a.size() != 0) begin n_fail++; $display("FAIL stall_leftover: got %0d bytes, required 0", exp_a.size()); end
        n_checks++; if (tmo_seen_a !== 1'b0) begin n_fail++; $display("FAIL stall_timeout: got %b, required 0", tmo_seen_a); end
    endtask

    task automatic test_timeout();
        bit done;
        int ov;
        push_a("0:Q");
        drive(0, "Q", "", 40, done, ov);
        n_checks++; if (!done) begin n_fail++; $display("FAIL tmo_q_done: got 0, required 1"); end
        a_valid = 2'b10;
        a_data = {8'h52, 8'h00};
        for (int k = 1; k <= 9; k++) begin
            tick();
            n_checks++;
            if (a_tmo_s !== (k == 9)) begin
                n_fail++;
                $display("FAIL tmo_pulse: cycle %0d got %b, required %b", k, a_tmo_s, (k == 9));
            end
            if (k < 9) begin
                n_checks++;
                if (a_ready_s[1] !== 1'b0) begin n_fail++; $display("FAIL tmo_ready1: cycle %0d got 1, required 0", k); end
            end
        end
        n_checks++; if (a_busy_s !== 1'b0) begin n_fail++; $display("FAIL tmo_busy: got %b, required 0", a_busy_s); end
        push_a("1:R\n");
        drive(0, "", "R\n", 40, done, ov);
        n_checks++; if (!done) begin n_fail++; $display("FAIL tmo_r_done: got 0, required 1"); end
        n_checks++; if (exp_a.size() != 0) begin n_fail++; $display("FAIL tmo_leftover: got %0d bytes, required 0", exp_a.size()); end
        n_checks++; if (a_owner !== 1'b1) begin n_fail++; $display("FAIL tmo_owner_hold: got %0d, required 1", a_owner); end
    endtask

    task automatic test_reset_midline();
        bit done;
        int ov;
        push_a("0:K\n");
        drive(0, "K\n", "", 40, done, ov);
        n_checks++; if (!done) begin n_fail++; $display("FAIL mid_k_done: got 0, required 1"); end
        push_a("1:M");
        a_valid = 2'b10;
        a_data = {8'h4D, 8'h00};
        for (int k = 0; k < 4; k++) tick();
        a_data = {8'h4E, 8'h00};
        #1;
        n_checks++; if (a_wr !== 1'b1) begin n_fail++; $display("FAIL mid_pre_wr: got %b, required 1", a_wr); end
        #1;
        rst = 1'b1;
        #1;
        n_checks++; if (a_wr !== 1'b0) begin n_fail++; $display("FAIL mid_rst_wr: got %b, required 0", a_wr); end
        n_checks++; if (a_ready !== 2'b00) begin n_fail++; $display("FAIL mid_rst_ready: got %b, required 00", a_ready); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b, required 0", a_busy); end
        tick();
        tick();
        n_checks++; if (exp_a.size() != 0) begin n_fail++; $display("FAIL mid_leftover: got %0d bytes, required 0", exp_a.size()); end
        rst = 1'b0;
        push_a("0:S\n1:T\n");
        drive(0, "S\n", "T\n", 40, done, ov);
        n_checks++; if (!done) begin n_fail++; $display("FAIL mid_after_done: got 0, required 1"); end
        n_checks++; if (ov != 0) begin n_fail++; $display("FAIL mid_after_order: got %0d cycles, required 0", ov); end
        n_checks++; if (exp_a.size() != 0) begin n_fail++; $display("FAIL mid_after_leftover: got %0d bytes, required 0", exp_a.size()); end
    endtask

    task automatic test_no_prefix();
        bit done;
        int ov;
        push_b("\n");
        drive(1, "", "\n", 20, done, ov);
        n_checks++; if (!done) begin n_fail++; $display("FAIL nopfx_lf_done: got 0, required 1"); end
        n_checks++; if (exp_b.size() != 0) begin n_fail++; $display("FAIL nopfx_lf_leftover: got %0d bytes, required 0", exp_b.size()); end
        n_checks++; if (b_owner !== 1'b1) begin n_fail++; $display("FAIL nopfx_owner: got %0d, required 1", b_owner); end
        push_b("A\nB\n");
        drive(1, "A\n", "B\n", 40, done, ov);
        n_checks++; if (!done) begin n_fail++; $display("FAIL nopfx_rr_done: got 0, required 1"); end
        n_checks++; if (ov != 0) begin n_fail++; $display("FAIL nopfx_rr_order: got %0d cycles, required 0", ov); end
        n_checks++; if (exp_b.size() != 0) begin n_fail++; $display("FAIL nopfx_rr_leftover: got %0d bytes, required 0", exp_b.size()); end
        push_b("C");
        drive(1, "C", "", 20, done, ov);
        tmo_seen_b = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        n_checks++; if (b_busy !== 1'b1) begin n_fail++; $display("FAIL notmo_busy: got %b, required 1", b_busy); end
        n_checks++; if (tmo_seen_b !== 1'b0) begin n_fail++; $display("FAIL notmo_pulse: got %b, required 0", tmo_seen_b); end
        push_b("\n");
        drive(1, "\n", "", 20, done, ov);
        n_checks++; if (!done) begin n_fail++; $display("FAIL notmo_done: got 0, required 1"); end
        n_checks++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL notmo_release: got %b, required 0", b_busy); end
        n_checks++; if (exp_b.size() != 0) begin n_fail++; $display("FAIL notmo_leftover: got %0d bytes, required 0", exp_b.size()); end
    endtask

    initial begin
        tmo_seen_a = 1'b0;
        tmo_seen_b = 1'b0;
        test_reset();
        test_contention();
        test_single_line();
        test_full_stall();
        test_timeout();
        test_reset_midline();
        test_no_prefix();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_line_arbiter.md
Name: uart_tx_line_arbiter

Overview:
- Shares the single UART TX FIFO write port (wr_i/wdata_i of the UART TX FIFO inside the peripheral wrapper) between NUM_REQ byte-stream requesters, e.g. CPU core, debug module, boot ROM.
- Arbitration is line-atomic: once a requester is granted, it keeps the FIFO until it sends LF (0x0A) or goes idle past a timeout. Console lines captured by the simulation monitor therefore never interleave.
- Optionally prefixes each granted line with "<id>:" so output can be attributed to a requester.

Parameters:
- NUM_REQ, 2, number of requesters (1..10, so the id is a single ASCII digit).
- PREFIX_EN, 1, 1 = emit ASCII ('0'+owner) then ':' before the first byte of each grant.
- LOCK_TIMEOUT, 1024, idle cycles in STREAM before a forced release; 0 disables the timeout.

Ports:
- sysclk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active high.
- req_valid_i  in  NUM_REQ  per-requester byte valid.
- req_data_i  in  NUM_REQ*8  per-requester byte; requester k uses bits [8k+7:8k].
- req_ready_o  out  NUM_REQ  per-requester accept.
- fifo_full_i  in  1  UART TX FIFO full.
- fifo_wr_o  out  1  FIFO write strobe.
- fifo_wdata_o  out  8  FIFO write data.
- busy_o  out  1  a grant is held (state != IDLE).
- owner_o  out  $clog2(NUM_REQ) (min 1)  current or last owner id.
- timeout_o  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset (async, all state): state=IDLE, rr_ptr=0, owner=0, idle_cnt=0. The state-derived outputs req_ready_o, fifo_wr_o, busy_o and timeout_o are all 0 during reset; fifo_wdata_o=0, owner_o=0.
- States: IDLE, PFX_ID, PFX_SEP, STREAM.
- IDLE:
  - If any req_valid_i is set, pick the first valid index at or after rr_ptr, wrapping. Latch it into owner.
  - Go to PFX_ID if PREFIX_EN, else STREAM. Nothing is written in IDLE.
  - With no valid requester, stay in IDLE.
- PFX_ID: when !fifo_full_i, fifo_wr_o=1 and fifo_wdata_o=8'h30+owner, then go to PFX_SEP. Otherwise hold.
- PFX_SEP: when !fifo_full_i, write 8'h3A (':') and go to STREAM. Otherwise hold.
- STREAM:
  - req_ready_o[owner] = !fifo_full_i; all other ready bits are 0.
  - On accept (valid & ready of the owner): fifo_wr_o=1 and fifo_wdata_o=owner's byte, in the same cycle. This path is combinational with zero latency.
  - If the accepted byte is 8'h0A: go to IDLE and set rr_ptr=(owner+1) mod NUM_REQ.
- Outside STREAM, all req_ready_o bits are 0.
- fifo_wr_o is never asserted while fifo_full_i=1.
- When fifo_wr_o=0, fifo_wdata_o=0.
- Timeout:
  - idle_cnt clears on entry to STREAM and on every accept.
  - It increments only while in STREAM with req_valid_i[owner]=0. Cycles stalled by fifo_full_i do not count.
  - When idle_cnt reaches LOCK_TIMEOUT-1 while still idle: next state is IDLE, rr_ptr=owner+1, timeout_o pulses 1 cycle.
  - With LOCK_TIMEOUT=0 the counter is inert.
  - Counter width: $clog2(LOCK_TIMEOUT+1); it saturates and never wraps.
- Simultaneous events:
  - An LF accept in the same cycle as the timeout threshold counts as a normal release; timeout_o stays 0. This cannot occur in practice, since an accept clears the counter.
- A requester deasserting valid mid-line keeps its grant until LF or timeout.
- A new grant always re-emits the prefix, even to the same owner after a timeout.
- owner_o holds its value in IDLE.
- NUM_REQ=1: rr_ptr is constant 0.
- Reset asserted mid-line truncates the line; no partial prefix or byte is written after rst_i rises.

Decomposition:
- Package uart_tx_arb_pkg holds:
  - the state enum arb_state_e (IDLE, PFX_ID, PFX_SEP, STREAM);
  - ASCII constants ASCII_LF=8'h0A, ASCII_COLON=8'h3A, ASCII_ZERO=8'h30.
- One sub-module, uart_tx_rr_pick: combinational round-robin picker, valid vector plus rr_ptr in, index and any-valid out.
- Counter and FSM live in the top.

Test Plan:
- NUM_REQ=2, PREFIX_EN=1: req0 sends "AB\n" -> FIFO receives 30 3A 41 42 0A, busy_o falls the cycle after the 0A accept.
- req0 and req1 both valid from reset with rr_ptr=0, req0 "X\n", req1 "Y\n" -> FIFO receives "0:X\n1:Y\n" with no interleave. req_ready_o[1] stays 0 until req0's LF is accepted.
- fifo_full_i held 1 for 5 cycles during PFX_SEP -> ':' is written exactly once after full drops, fifo_wr_o=0 throughout the stall, and no timeout occurs.
- LOCK_TIMEOUT=8: req0 sends "Q" then drops valid while req1 is valid -> timeout_o pulses 8 cycles after the Q accept, then "1:" is written and req1 is served.
- Async rst_i pulse in the middle of STREAM -> fifo_wr_o and req_ready_o go to 0 immediately. After release, the first grant goes to req0 (rr_ptr=0) with a fresh prefix.
- PREFIX_EN=0, LOCK_TIMEOUT=0, req1 sends 0x0A only -> one FIFO write of 0A, and the next grant goes to req0 via rr_ptr=0.
